// File: rtl/alu_mult_seq.sv
// alu_mult_seq: shift-add unsigned multiplier that borrows the execute-stage
// ALU as its adder and returns the low 32 bits of a*b.
module alu_mult_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic        product_zero,
    output logic [31:0] alu_port_a,
    output logic [31:0] alu_port_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    localparam logic [3:0] ALU_ADD = 4'b0101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [4:0]  cnt;
    logic        last_iter;

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, status flags and ALU drive; ALU is quiescent outside RUN.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        alu_op     = ALU_ADD;
        alu_port_a = '0;
        alu_port_b = '0;
        last_iter  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    next_state = (b == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                alu_port_a = acc;
                alu_port_b = mplier[0] ? mcand : '0;
                last_iter  = (cnt == 5'd31) ||
                             (EARLY_EXIT && (mplier[31:1] == '0));
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Shift-add datapath; product is captured on the edge entering DONE
    // so it is already valid while done is high.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            cnt          <= '0;
            product      <= '0;
            product_zero <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        cnt <= '0;
                        if (b == '0) begin
                            product      <= '0;
                            product_zero <= 1'b1;
                        end else begin
                            mcand  <= a;
                            mplier <= b;
                        end
                    end
                end
                RUN: begin
                    acc    <= alu_result;
                    mcand  <= {mcand[30:0], 1'b0};
                    mplier <= {1'b0, mplier[31:1]};
                    cnt    <= cnt + 5'd1;
                    if (last_iter) begin
                        product      <= alu_result;
                        product_zero <= alu_zero;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_seq.sv
// tb_alu_mult_seq: random and directed multiplies against a 64-bit
// arithmetic reference, scored by a negedge monitor.
module tb_alu_mult_seq;

    localparam bit         EE     = 1'b1;
    localparam logic [3:0] OP_ADD = 4'b0101;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        product_zero;
    logic [31:0] alu_port_a;
    logic [31:0] alu_port_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;

    typedef struct {
        logic [31:0] prod;
        logic        pz;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] pbq[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          ndone    = 0;
    logic [31:0] held_p   = 32'd0;
    logic        held_z   = 1'b1;

    alu_mult_seq #(.EARLY_EXIT(EE)) dut (
        .CLK          (clk),
        .nRST         (nrst),
        .start        (start),
        .a            (a_in),
        .b            (b_in),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .product_zero (product_zero),
        .alu_port_a   (alu_port_a),
        .alu_port_b   (alu_port_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero)
    );

    // Stand-in ALU: adds on ADD, anything else gives an obviously wrong value.
    always_comb begin
        alu_result = (alu_op == OP_ADD) ? alu_port_a + alu_port_b
                                        : alu_port_a ^ alu_port_b ^ 32'hDEAD_BEEF;
        alu_zero   = (alu_result == 32'd0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_lat(input logic [31:0] b);
        int m = -1;
        if (b == 32'd0) return 1;
        if (!EE) return 33;
        for (int i = 0; i < 32; i++) if (b[i]) m = i;
        return m + 2;
    endfunction

    // Monitor: scores every done pulse and checks hold/quiescent behaviour.
    always @(negedge clk) begin
        if (nrst) begin
            if (done) begin
                ndone++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("product", product, e.prod);
                    chk("product_zero", {31'd0, product_zero}, {31'd0, e.pz});
                    chk("latency", cyc - e.t0, e.lat);
                    held_p = e.prod;
                    held_z = e.pz;
                end
            end else begin
                chk("product_hold", product, held_p);
                chk("pz_hold", {31'd0, product_zero}, {31'd0, held_z});
            end
            if (!busy || done) begin
                chk("alu_op_quiet", {28'd0, alu_op}, {28'd0, OP_ADD});
                chk("alu_a_quiet", alu_port_a, 32'd0);
                chk("alu_b_quiet", alu_port_b, 32'd0);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        exp_t x;
        full   = {32'd0, a} * {32'd0, b};
        x.prod = full[31:0];
        x.pz   = (full[31:0] == 32'd0);
        x.lat  = ref_lat(b);
        x.t0   = cyc;
        sb.push_back(x);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        pbq.delete();
        for (int i = 0; i < 60; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) pbq.push_back(alu_port_b);
            @(negedge clk);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got=none want=done at cycle %0d", cyc);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        issue(a, b);
        wait_done();
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] want_pb[3];
        want_pb[0] = 32'd0;
        want_pb[1] = 32'd14;
        want_pb[2] = 32'd28;
        nrst  = 1'b0;
        start = 1'b0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_product", product, 32'd0);
        chk("rst_pz", {31'd0, product_zero}, 32'd1);
        chk("rst_alu_op", {28'd0, alu_op}, {28'd0, OP_ADD});
        chk("rst_alu_a", alu_port_a, 32'd0);
        chk("rst_alu_b", alu_port_b, 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        run_op(32'd7, 32'd6);
        chk("pb_count", pbq.size(), 32'd3);
        for (int i = 0; i < 3; i++)
            chk("pb_seq", (i < pbq.size()) ? pbq[i] : 32'hFFFF_FFFF, want_pb[i]);

        run_op(32'h1234_5678, 32'd0);
        chk("b0_no_run", pbq.size(), 32'd0);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("ff_run_cycles", pbq.size(), 32'd32);

        issue(32'h0001_0000, 32'h0001_0000);
        repeat (2) @(negedge clk);
        a_in  = 32'd1;
        b_in  = 32'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        chk("one_done_busy", {31'd0, busy}, 32'd0);

        issue(32'd9, 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_dropped", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);

        issue(32'd5, 32'h8000_0000);
        repeat (5) @(negedge clk);
        nrst = 1'b0;
        sb.delete();
        held_p = 32'd0;
        held_z = 1'b1;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_product", product, 32'd0);
        repeat (40) @(negedge clk);
        run_op(32'd3, 32'd3);

        for (int n = 0; n < 25; n++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0
                                             : ($urandom >> $urandom_range(0, 31));
            run_op(ra, rb);
        end

        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
- Sequential unsigned multiplier that drives the ALU from the initiator side. It owns port_a, port_b and alu_op, and consumes result and zero.
- Uses the ALU as its adder in a shift-add loop and produces the low 32 bits of a×b.
- Sits beside the ALU in the execute stage and serves multi-cycle multiply instructions.
- Lets the datapath reuse the existing ALU instead of instantiating a second 32-bit adder.

Parameters:
- EARLY_EXIT, 1: 1 = stop iterating once the remaining multiplier is zero; 0 = always run 32 iterations.

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  synchronous, active-low reset; sampled on the rising edge of CLK
- start  input  1  request; sampled only in IDLE
- a  input  32 (word_t)  multiplicand
- b  input  32 (word_t)  multiplier
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; product valid in that cycle
- product  output  32 (word_t)  low 32 bits of a×b; held until the next accepted start
- product_zero  output  1  product == 0; held with product
- alu_port_a  output  32 (word_t)  to ALU port_a
- alu_port_b  output  32 (word_t)  to ALU port_b
- alu_op  output  aluop_t  to ALU alu_op
- alu_result  input  32 (word_t)  from ALU result
- alu_zero  input  1  from ALU zero

Behaviour:
- Reset (nRST low at a CLK edge):
  - state = IDLE.
  - busy = 0, done = 0, product = 0, product_zero = 1.
  - Internal acc, mcand, mplier and cnt = 0.
  - A reset mid-RUN aborts the operation; no done pulse is produced.
- ALU drive in IDLE and DONE: alu_op = ALU_ADD, alu_port_a = 0, alu_port_b = 0, so the ALU is quiescent.
- IDLE:
  - start = 1 and b != 0: mcand <= a, mplier <= b, acc <= 0, cnt <= 0; go to RUN.
  - start = 1 and b == 0: acc <= 0; go directly to DONE, with no ALU iteration.
  - start = 0: stay in IDLE.
- RUN, one ALU add per cycle (combinational ALU, result consumed the same cycle):
  - Drive alu_op = ALU_ADD, alu_port_a = acc, alu_port_b = mplier[0] ? mcand : 0.
  - At the clock edge: acc <= alu_result; zflag <= alu_zero; mcand <= mcand << 1 (bit 31 discarded); mplier <= mplier >> 1; cnt <= cnt + 1.
  - Exit to DONE when cnt == 31, or when EARLY_EXIT = 1 and (mplier >> 1) == 0.
- DONE, one cycle:
  - done = 1, busy = 1.
  - product <= acc and product_zero <= (b == 0 path ? 1 : zflag); both are registered on entry so they are valid during the done cycle.
  - Next state is IDLE.
- start is ignored while busy = 1. start asserted in the DONE cycle is dropped and must be re-presented in IDLE.
- Latency from the start edge to the done cycle:
  - EARLY_EXIT = 1: (msb index of b) + 2 cycles; 1 cycle when b = 0.
  - EARLY_EXIT = 0: 33 cycles for b != 0.
- Arithmetic is modulo 2^32. High product bits are discarded, with no overflow indication. ALU negative and overflow are not used.
- product and product_zero change only in the DONE cycle and hold their values otherwise.

Test Plan:
- Reset then idle: nRST low 2 cycles → product = 0, product_zero = 1, busy = 0, done = 0; alu_op = ALU_ADD, alu ports = 0.
- a = 7, b = 6 (EARLY_EXIT = 1) → 3 RUN cycles with alu_port_b = 0, 14, 28; done in cycle 4 after start; product = 42, product_zero = 0.
- a = 0x12345678, b = 0 → done 1 cycle after start, no RUN cycles; product = 0, product_zero = 1.
- a = 0xFFFFFFFF, b = 0xFFFFFFFF → 32 RUN cycles, done at cycle 33; product = 0x00000001.
- a = 0x00010000, b = 0x00010000 → wrap case; product = 0, product_zero = 1; start pulsed mid-RUN is ignored, with exactly one done pulse.
- nRST low during RUN of a = 5, b = 0x80000000 → state returns to IDLE, no done pulse, product = 0; a new start with a = 3, b = 3 then gives product = 9.
